// File: rtl/prog_loader_if.sv
// Host byte stream plus instruction-memory write port of the X9 program loader.
// The loader takes the slave side; the host / memory model takes the master side.
interface prog_loader_if #(
  parameter int D = 12
);
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         im_wr_en;
  logic [D-1:0] im_addr;
  logic [8:0]   im_wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_wr_en, im_addr, im_wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_wr_en, im_addr, im_wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// X9 program loader: packs host byte pairs into 9-bit words, writes them to
// instruction memory with the core held in reset, then runs the core and reports.
module prog_loader #(
  parameter int D       = 12,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  prog_loader_if.slave  bus,
  output logic          core_reset,
  input  logic          done,
  output logic [1:0]    status,
  output logic [1:0]    err_code,
  output logic [D:0]    instr_count,
  output logic [CW-1:0] run_cycles
);

  typedef enum logic [2:0] {
    LOAD_LO,
    LOAD_HI,
    WRITE,
    RUN,
    PASS,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_FORMAT  = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  localparam logic [CW-1:0] LP_LAST_CYCLE = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  err_t          r_err;
  err_t          w_err_val;
  logic          w_set_err;
  logic          w_xfer;
  logic          w_fmt_bad;
  logic [7:0]    r_lo;
  logic          r_last;
  logic [D-1:0]  r_wptr;
  logic [D-1:0]  r_addr;
  logic [8:0]    r_wdata;
  logic          r_core_reset;
  logic [D:0]    r_count;
  logic [CW-1:0] r_cycles;

  assign bus.in_ready   = (r_state == LOAD_LO) || (r_state == LOAD_HI);
  assign bus.im_wr_en   = (r_state == WRITE);
  assign bus.im_addr    = r_addr;
  assign bus.im_wr_data = r_wdata;
  assign w_xfer         = bus.in_valid && bus.in_ready;
  assign w_fmt_bad      = |bus.in_data[6:1];

  assign core_reset  = r_core_reset;
  assign err_code    = r_err;
  assign instr_count = r_count;
  assign run_cycles  = r_cycles;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    w_err_val = ERR_NONE;
    if (restart) begin
      w_next = LOAD_LO;
    end else begin
      case (r_state)
        LOAD_LO: if (w_xfer) w_next = LOAD_HI;
        LOAD_HI: begin
          if (w_xfer) begin
            if (w_fmt_bad) begin
              w_next    = ERROR;
              w_set_err = 1'b1;
              w_err_val = ERR_FORMAT;
            end else begin
              w_next = WRITE;
            end
          end
        end
        WRITE: begin
          if (r_last) begin
            w_next = RUN;
          end else if (r_wptr == '1) begin
            w_next    = ERROR;
            w_set_err = 1'b1;
            w_err_val = ERR_OVERFLOW;
          end else begin
            w_next = LOAD_LO;
          end
        end
        RUN: begin
          // done outranks a timeout landing on the same cycle
          if (done) begin
            w_next = PASS;
          end else if (r_cycles == LP_LAST_CYCLE) begin
            w_next    = ERROR;
            w_set_err = 1'b1;
            w_err_val = ERR_TIMEOUT;
          end
        end
        PASS:    w_next = PASS;
        ERROR:   w_next = ERROR;
        default: w_next = LOAD_LO;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      RUN:     status = 2'b01;
      PASS:    status = 2'b10;
      ERROR:   status = 2'b11;
      default: status = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LOAD_LO;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lo         <= '0;
      r_last       <= 1'b0;
      r_wptr       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_reset <= 1'b1;
      r_err        <= ERR_NONE;
      r_count      <= '0;
      r_cycles     <= '0;
    end else begin
      // Registered from next state so the core leaves reset on the first RUN cycle.
      r_core_reset <= (w_next != RUN);
      if (restart) begin
        r_wptr   <= '0;
        r_count  <= '0;
        r_cycles <= '0;
        r_err    <= ERR_NONE;
      end else begin
        if (w_set_err) r_err <= w_err_val;
        if (r_state == LOAD_LO && w_xfer) r_lo <= bus.in_data;
        if (r_state == LOAD_HI && w_xfer && !w_fmt_bad) begin
          r_addr  <= r_wptr;
          r_wdata <= {bus.in_data[0], r_lo};
          r_last  <= bus.in_data[7];
        end
        if (r_state == WRITE) begin
          r_wptr  <= r_wptr + 1'b1;
          r_count <= r_count + 1'b1;
        end
        // The timeout cycle itself is not counted; the done cycle is.
        if (r_state == RUN && w_next != ERROR) r_cycles <= r_cycles + 1'b1;
      end
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side initiator for the X9 core. It receives a byte stream on a valid/ready interface and packs each byte pair into one 9-bit instruction.
- It writes each instruction into the instruction memory write port while holding the core in reset.
- After the last instruction it releases the core, waits for the core's done flag, and reports the pass/error status and the run-cycle count.

Parameters:
- D, 12, instruction memory address width; must match the core's program counter width.
- CW, 16, width of the run-cycle counter.
- TIMEOUT, 4096, maximum number of run cycles before a timeout error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- restart  in  1  single-cycle pulse; aborts any activity and starts a new load
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  loader accepts a byte this cycle
- im_wr_en  out  1  instruction memory write strobe
- im_addr  out  D  instruction memory write address
- im_wr_data  out  9  instruction word (mach_code)
- core_reset  out  1  active-high reset to the core
- done  in  1  core done flag
- status  out  2  00 loading, 01 running, 10 pass, 11 error
- err_code  out  2  0 none, 1 bad format, 2 overflow, 3 timeout
- instr_count  out  D+1  number of instructions written
- run_cycles  out  CW  cycles spent in RUN

Behaviour:
- Reset values (asynchronous, reset=0): state LOAD_LO; im_wr_en 0; im_addr 0; im_wr_data 0; core_reset 1; status 00; err_code 0; instr_count 0; run_cycles 0; wptr 0; lo byte register 0.
- Handshake: a byte transfers when in_valid and in_ready are both high at a rising clk edge. in_ready = 1 only in LOAD_LO and LOAD_HI, and it is combinational from state.
- Word format:
  - byte0 = mach_code[7:0].
  - byte1[0] = mach_code[8].
  - byte1[7] = last flag.
  - byte1[6:1] must be 0.
- LOAD_LO: on transfer, latch byte0 and go to LOAD_HI.
- LOAD_HI: on transfer, check byte1.
  - If byte1[6:1] != 0: go to ERROR with err_code 1; nothing is written.
  - Otherwise register im_addr=wptr and im_wr_data={byte1[0],lo}, latch the last flag, and go to WRITE.
- WRITE (exactly one cycle):
  - im_wr_en=1; instr_count and wptr increment at the end of the cycle.
  - If last=1, go to RUN.
  - Else if wptr was 2^D-1, go to ERROR with err_code 2. The final word is still written.
  - Else go to LOAD_LO.
- Write latency: im_wr_en asserts on the cycle after the byte1 transfer, for 1 cycle. Maximum accept rate is 1 instruction per 3 cycles.
- RUN:
  - core_reset=0 (registered, so it falls on the first RUN cycle); status 01; run_cycles increments every RUN cycle.
  - If done=1, go to PASS. run_cycles freezes, and the cycle that samples done is counted.
  - Else if run_cycles reaches TIMEOUT-1, go to ERROR with err_code 3.
  - If done and the timeout occur in the same cycle, PASS wins.
  - done is ignored in every state other than RUN.
- PASS: status 10; core_reset 1. State is sticky until restart or reset.
- ERROR: status 11; core_reset 1; err_code is held. State is sticky until restart or reset.
- core_reset = 1 in every state except RUN.
- restart has priority over every transition in every state. The next state is LOAD_LO, with wptr, instr_count, run_cycles and err_code cleared. Instruction memory contents are not cleared.
- Asserting reset in any state (including mid-load or mid-run) returns all outputs to their reset values asynchronously. An in-flight half word (lo latched) is discarded.
- instr_count has D+1 bits so that a full memory of 2^D words is representable.

Test Plan:
- Load 3 words (0x0A5,0x1FF,last 0x003):
  - bytes A5,00,FF,01,03,80 with in_valid held high.
  - Required: 3 writes at addresses 0,1,2 with data 0x0A5,0x1FF,0x003; im_wr_en asserts 1 cycle after each byte1; in_ready=0 during each WRITE cycle; instr_count=3; core_reset falls after the third write.
- Run to completion: after the load above, assert done on the 6th RUN cycle.
  - Required: status=10, run_cycles=6, core_reset=1.
- Bad format: byte1=0x04.
  - Required: no write, status=11, err_code=1, in_ready=0; restart then returns status 00 with instr_count=0.
- Timeout: TIMEOUT=8 and done held at 0.
  - Required: ERROR with err_code=3 after exactly 8 RUN cycles, run_cycles=7, core_reset=1.
- Overflow: D=2, load 4 words with none marked last.
  - Required: writes at addresses 0-3, then err_code=2, instr_count=4.
- Asynchronous reset mid-load (after byte0, between clock edges) and mid-run:
  - Required: all outputs at reset values immediately; the first byte after reset is treated as byte0 at address 0.
